// File: rtl/pio_change_capture.sv
// Captures every change of a PIO value with a timestamp into a small FIFO exposed as valid/ready.
// One cycle from change to out_valid; when the FIFO is full without a pop, events drop and set sticky overflow.
module pio_change_capture #(
    parameter int DATA_W = 10,
    parameter int DEPTH  = 4,
    parameter int TS_W   = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DATA_W-1:0]        pio_in,
    input  logic                     enable,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [TS_W-1:0]          out_ts,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    input  logic                     clr_overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int EW = DATA_W + TS_W;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    logic [DATA_W-1:0] prev_q;
    logic [TS_W-1:0]   ts_q, ts_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic              ovf_q, ovf_d;
    logic [EW-1:0]     mem_q [DEPTH];

    logic change, pop, full, push, drop;
    logic [EW-1:0] head;

    always_comb begin
        change   = enable && (pio_in != prev_q);
        pop      = (level_q != '0) && out_ready;
        full     = (level_q == FULL_LVL);
        // A pop in the same cycle frees the slot, so a full FIFO can still accept.
        push     = change && (!full || pop);
        drop     = change && full && !pop;

        level_d  = level_q;
        if (push && !pop) begin
            level_d = level_q + LW'(1);
        end else if (pop && !push) begin
            level_d = level_q - LW'(1);
        end

        ovf_d    = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (clr_overflow) begin
            ovf_d = 1'b0;
        end

        ts_d     = enable ? ts_q + TS_W'(1) : ts_q;
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q   <= '0;
            ts_q     <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            prev_q   <= pio_in;
            ts_q     <= ts_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
        end
    end

    // Entries are zero-filled so the head reads 0 after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr_q] <= {pio_in, ts_q};
        end
    end

    assign head      = mem_q[rd_ptr_q];
    assign out_data  = head[EW-1:TS_W];
    assign out_ts    = head[TS_W-1:0];
    assign out_valid = (level_q != '0);
    assign level     = level_q;
    assign overflow  = ovf_q;

endmodule
